// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data access) arbiter onto a single
// shared memory with a fixed access time of LATENCY cycles.
// Optional macro ARB_DATA_PRIORITY_EN: when defined the data port always wins
// simultaneous requests; otherwise simultaneous requests are served round-robin.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_done,

    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,

    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,

    output logic                 busy,
    output logic                 owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Remaining access cycles; LATENCY never exceeds 3, so two bits suffice.
    logic [1:0] cnt;

    // Request captured at grant; the memory side is driven only from these so
    // that requester-side changes during an access cannot disturb it.
    logic                 lat_we;
    logic [WORD_SIZE-1:0] lat_addr;
    logic [WORD_SIZE-1:0] lat_wdata;

    logic any_req;
    logic grant_d;
    logic last_cycle;

    assign any_req    = i_req | d_req;
    assign last_cycle = (cnt == 2'd1);

    // Arbitration: decides which port is granted if a grant happens this cycle.
`ifdef ARB_DATA_PRIORITY_EN
    assign grant_d = d_req;
`else
    // Round-robin: on a tie the port that was not the last owner wins.
    assign grant_d = d_req & (~i_req | ~owner);
`endif

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE grants, ACCESS counts down, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (last_cycle) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control registers: access counter and current/last owner.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= 2'd0;
            owner <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cnt   <= 2'(LATENCY);
                        owner <= grant_d;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 2'd1;
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    // Request latch: address, write data and direction of the granted port.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && any_req) begin
            lat_we    <= grant_d & d_we;
            lat_addr  <= grant_d ? d_addr : i_addr;
            lat_wdata <= d_wdata;
        end
    end

    // Read-data registers: loaded only when a read finishes on that port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if ((state == ACCESS) && last_cycle && !lat_we) begin
            if (owner) begin
                d_rdata <= m_rdata;
            end else begin
                i_rdata <= m_rdata;
            end
        end
    end

    // Memory-side and status outputs decoded from state and latched request.
    always_comb begin
        m_readM   = 1'b0;
        m_writeM  = 1'b0;
        m_address = '0;
        m_wdata   = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        busy      = (state != IDLE);
        if (state == ACCESS) begin
            m_readM   = ~lat_we;
            m_writeM  = lat_we;
            m_address = lat_addr;
            if (lat_we) begin
                m_wdata = lat_wdata;
            end
        end
        if (state == DONE) begin
            i_done = ~owner;
            d_done = owner;
        end
    end

endmodule
